// File: rtl/rgt_shift_pkg.sv
// Shared types and constants for the iterative right shifter.
package rgt_shift_pkg;

    // Shift mode encodings; 2'b11 is treated as logical.
    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/rgt_shift_stage.sv
// One logarithmic right-shift stage: shifts by amt_i when enabled, else passes through.
module rgt_shift_stage
    import rgt_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] word_c_o
);

    logic [WIDTH-1:0] fill;

    // Place the fill pattern above the word and shift the pair; the low half is the result.
    always_comb begin
        fill = '0;
        case (mode_i)
            MODE_ASR: fill = {WIDTH{sign_i}};
            MODE_ROR: fill = word_i;
            default:  fill = '0;
        endcase
        word_c_o = en_i ? WIDTH'({fill, word_i} >> amt_i) : word_i;
    end

endmodule

// File: rtl/rgt_shift_seq.sv
// Iterative right barrel shifter: one log stage per clock, valid/ready on both sides.
module rgt_shift_seq
    import rgt_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_sv,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = (SHW > 1) ? $clog2(SHW) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   sv_q, sv_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [CNTW-1:0]  stage_q, stage_d;
    logic [WIDTH-1:0] stage_word;

    // Single shared stage; amount is 2^k for the current stage counter.
    rgt_shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .word_i   (data_q),
        .amt_i    (SHW'(1) << stage_q),
        .en_i     (sv_q[stage_q]),
        .mode_i   (mode_q),
        .sign_i   (sign_q),
        .word_c_o (stage_word)
    );

    // State, counter and working registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            sv_q    <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sv_q    <= sv_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            stage_q <= stage_d;
        end
    end

    // Next-state: capture in IDLE, one stage per cycle in SHIFT, hold result in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sv_d    = sv_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    sv_d    = in_sv;
                    mode_d  = in_mode;
                    sign_d  = in_data[WIDTH-1];
                    stage_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d  = stage_word;
                stage_d = stage_q + CNTW'(1);
                if (stage_q == CNTW'(SHW - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register; data is the working word.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_rgt_shift_seq.sv
// Self-checking bench for rgt_shift_seq: directed plan, backpressure, reset, sweep, random.
module tb_rgt_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_sv;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    rgt_shift_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sv     (in_sv),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference: the whole shift in one arithmetic expression.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sv, input logic [1:0] m);
        case (m)
            2'b01:   return 32'($signed(d) >>> sv);
            2'b10:   return (sv == 0) ? d : ((d >> sv) | (d << (32 - sv)));
            default: return d >> sv;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic accept(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_sv = s; in_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_sv    = 5'($urandom);
        in_mode  = 2'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Full transaction with out_ready high: latency, data, single-cycle valid, return to IDLE.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                          input logic [31:0] exp, input string tag);
        int lat;
        out_ready = 1'b1;
        accept(d, s, m, tag);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_data"}, out_data, exp);
        @(posedge clk); #1;
        check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] snap;
        logic bad;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_sv = '0; in_mode = '0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Directed cases
        run_op(32'h80000000, 5'd31, 2'b00, 32'h00000001, "lsr31");
        run_op(32'h80000000, 5'd4,  2'b01, 32'hF8000000, "asr4");
        run_op(32'h00000001, 5'd1,  2'b10, 32'h80000000, "ror1");
        run_op(32'h0000000F, 5'd4,  2'b10, 32'hF0000000, "ror4");
        run_op(32'hDEADBEEF, 5'd0,  2'b01, 32'hDEADBEEF, "sv0");
        run_op(32'hF0000000, 5'd4,  2'b11, 32'h0F000000, "mode3");

        // Backpressure: result held for 3 cycles, a stray request must be ignored
        out_ready = 1'b0;
        accept(32'hA5A5F00F, 5'd12, 2'b01, "bp");
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd5);
        check("bp_data", out_data, 32'hFFFA5A5F);
        snap = out_data;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; in_data = 32'hCAFEF00D; in_sv = 5'd3; in_mode = 2'b00;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, snap);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad = 1'b1;
        end
        check("bp_no_capture", 32'(bad), 32'd0);

        // Reset two cycles after acceptance
        accept(32'h12345678, 5'd8, 2'b00, "rst_mid");
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", out_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        check("rst_mid_stale", 32'(bad), 32'd0);
        run_op(32'h12345678, 5'd8, 2'b00, 32'h00123456, "after_rst");

        // Sweep against the model
        for (int d = 1; d <= 8; d++) begin
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 4; m++) begin
                    logic [31:0] dd;
                    logic [4:0]  ss;
                    dd = (m == 1 && k == 1) ? ~32'(d) : 32'(d);
                    ss = (k == 0) ? 5'd1 : 5'd31;
                    run_op(dd, ss, 2'(m), ref_shift(dd, int'(ss), 2'(m)), "sweep");
                end
            end
        end

        // Random operands against the model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] rd;
            logic [4:0]  rs;
            logic [1:0]  rm;
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            rm = 2'($urandom_range(0, 3));
            run_op(rd, rs, rm, ref_shift(rd, int'(rs), rm), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
